// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared store size codes and RMW FSM state encodings
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_WRITE   = 2'b10,
    ST_RESP    = 2'b11
  } state_e;

endpackage

// File: rtl/lane_merge.sv
// rtl/lane_merge.sv - overlays right-aligned byte/half store data onto an old memory word
module lane_merge
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  offset,
  input  logic [1:0]        size,
  output logic [DATA_W-1:0] merged
);

  localparam int NB = DATA_W / 8;

  // One extra bit so offset+1 cannot wrap onto lane 0 at the top lane.
  logic [OFF_W:0] off_ext;
  logic [OFF_W:0] off_hi;

  assign off_ext = {1'b0, offset};
  assign off_hi  = off_ext + 1'b1;

  always_comb begin
    merged = old_word;
    if (size == SZ_WORD) begin
      merged = data;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if ((size == SZ_BYTE || size == SZ_HALF) && (OFF_W+1)'(i) == off_ext)
          merged[i*8 +: 8] = data[7:0];
        if (size == SZ_HALF && (OFF_W+1)'(i) == off_hi)
          merged[i*8 +: 8] = data[15:8];
      end
    end
  end

endmodule

// File: rtl/rmw_store_unit.sv
// rtl/rmw_store_unit.sv - byte/half/word store unit using read-modify-write of full memory words
module rmw_store_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              err
);

  localparam int OFF_W = $clog2(DATA_W/8);

  state_e              state_q;
  logic [1:0]          size_q;
  logic [OFF_W-1:0]    off_q;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                done_q;
  logic                err_q;

  logic [OFF_W-1:0]    req_off;
  logic                reject_d;
  logic [DATA_W-1:0]   merged;

  assign req_off = req_addr[OFF_W-1:0];

  always_comb begin
    reject_d = 1'b0;
    case (req_size)
      SZ_BYTE: reject_d = 1'b0;
      SZ_HALF: reject_d = req_off[0];
      SZ_WORD: reject_d = (req_off != '0);
      default: reject_d = 1'b1;
    endcase
  end

  lane_merge #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_lane_merge (
    .old_word (mem_rdata),
    .data     (data_q),
    .offset   (off_q),
    .size     (size_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      size_q      <= SZ_BYTE;
      off_q       <= '0;
      data_q      <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Write and response strobes are single-cycle pulses.
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            mem_addr_q <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            size_q     <= req_size;
            off_q      <= req_off;
            data_q     <= req_data;
            if (reject_d) begin
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state_q     <= ST_WRITE;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= req_data;
              done_q      <= 1'b1;
            end else begin
              state_q  <= ST_RD_WAIT;
              mem_rd_q <= 1'b1;
            end
          end
        end
        ST_RD_WAIT: begin
          if (mem_rvalid) begin
            state_q     <= ST_WRITE;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= merged;
            done_q      <= 1'b1;
          end
        end
        ST_WRITE: state_q <= ST_IDLE;
        ST_RESP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/rmw_store_unit.md
RMW_STORE_UNIT -- requirements
Module: rmw_store_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width in bits; legal values are 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  store request present.
REQ-006 SHALL have port req_ready  out  1  unit can accept a request this cycle.
REQ-007 SHALL have port req_addr  in  ADDR_W  byte address of the store.
REQ-008 SHALL have port req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_data  in  DATA_W  store data, right-aligned (byte at [7:0]).
REQ-010 SHALL have port mem_addr  out  ADDR_W  word-aligned address; low log2(DATA_W/8) bits are zero.
REQ-011 SHALL have port mem_rd  out  1  read strobe.
REQ-012 SHALL have port mem_rdata  in  DATA_W  read data.
REQ-013 SHALL have port mem_rvalid  in  1  mem_rdata valid this cycle.
REQ-014 SHALL have port mem_wr  out  1  full-word write strobe.
REQ-015 SHALL have port mem_wdata  out  DATA_W  merged write word.
REQ-016 SHALL have port done  out  1  one-cycle pulse when a store completes or is rejected.
REQ-017 SHALL have port err  out  1  valid with done; 1 = misaligned or illegal size, no write performed.

Function
REQ-018 SHALL use FSM states IDLE, RD_WAIT, WRITE, RESP.
REQ-019 SHALL hold req_ready=1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-020 SHALL latch addr, size, offset (addr[log2(DATA_W/8)-1:0]) and data on accept.
REQ-021 SHALL treat word as the full DATA_W; a word store with nonzero offset, a half store with odd offset, or size 11 SHALL be rejected: IDLE->RESP, done=1 and err=1 in RESP, mem_rd and mem_wr never asserted.
REQ-022 SHALL, for an aligned word store, go IDLE->WRITE: mem_wr=1 and mem_wdata=req_data in the cycle after accept, with done=1 in that same cycle, then return to IDLE.
REQ-023 SHALL, for a byte or half store, go IDLE->RD_WAIT with mem_rd=1 held every RD_WAIT cycle until mem_rvalid=1, with no timeout.
REQ-024 SHALL, on the mem_rvalid edge, register merged = mem_rdata with lanes at offset replaced by the low 8 (byte) or 16 (half) bits of the data, then enter WRITE.
REQ-025 SHALL assert mem_wr=1, mem_wdata=merged and done=1 for exactly one WRITE cycle, then return to IDLE.
REQ-026 SHALL ignore mem_rvalid outside RD_WAIT.
REQ-027 SHALL hold mem_addr at the latched word-aligned address from the accept edge until return to IDLE.
REQ-028 SHALL register all outputs except req_ready, which is decoded from state.
REQ-029 SHALL have err=0 whenever done=0.
REQ-030 SHALL keep at most one request in flight; back-to-back requests are accepted at the earliest cycle IDLE is re-entered.

Reset
REQ-031 SHALL drive state=IDLE, req_ready=1, and mem_rd, mem_wr, done, err, mem_addr, mem_wdata to 0 while reset=1, asynchronously.
REQ-032 SHALL abandon any in-flight store on reset without any write or done pulse; a pending mem_rvalid arriving after reset is ignored.

Structure
REQ-033 SHALL take the size codes SZ_BYTE, SZ_HALF, SZ_WORD and the FSM state encodings from shared package mem_pkg.
REQ-034 SHALL place the lane merge in a combinational sub-module lane_merge, parameterised on DATA_W (inputs: old word, data, offset, size; output: merged word).

Verification
REQ-035 SHALL test a byte store: DATA_W=32, addr=0x1002, data=0xAB, rdata=0x11223344 after 3 wait cycles -> mem_addr=0x1000, mem_wdata=0x11AB3344, one done, err=0.
REQ-036 SHALL test a half store: addr=0x2006, data=0xBEEF, rdata=0xFFFFFFFF -> mem_wdata=0xBEEFFFFF.
REQ-037 SHALL test an aligned word store: addr=0x3000, data=0xDEADBEEF -> mem_wr in the cycle after accept, mem_rd never asserted.
REQ-038 SHALL test rejection: half at addr=0x0001, then size=11 -> done=1 and err=1 each time, zero mem_wr and zero mem_rd pulses.
REQ-039 SHALL test reset mid-operation: reset asserted in RD_WAIT, then mem_rvalid=1 -> outputs at reset values, no mem_wr, next request serviced normally.
REQ-040 SHALL test DATA_W=64: byte store at addr=0x0007, data=0x5A, rdata=0 -> mem_wdata=0x5A00000000000000.
